// File: rtl/sram_word_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_word_writer_pkg
// Description : Shared definitions for the SRAM word writer: sequencer state
//               encodings, SRAM data width and half-word offsets within a
//               32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_word_writer_pkg;

    // SRAM data bus width
    localparam int SRAM_DW = 16;

    // Half-word offsets of a word relative to its base half-address
    localparam int HALF_LO = 0;
    localparam int HALF_HI = 1;

    // Write sequencer states: each half-word goes SETUP -> PULSE -> HOLD
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP_L = 3'd1,
        ST_PULSE_L = 3'd2,
        ST_HOLD_L  = 3'd3,
        ST_SETUP_H = 3'd4,
        ST_PULSE_H = 3'd5,
        ST_HOLD_H  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_word_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock request FIFO with registered occupancy count.
//               Pointers wrap modulo DEPTH (DEPTH must be a power of two).
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset, empties the FIFO
//   i_push       in   write i_push_data (ignored when full)
//   i_push_data  in   entry to store
//   i_pop        in   discard head entry (ignored when empty)
//   o_head       out  current head entry
//   o_full       out  DEPTH entries stored
//   o_empty      out  no entries stored
//   o_count      out  number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: occupancy is tracked by the count/pointers
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_word_writer.sv
`default_nettype none
// ============================================================================
// Module      : sram_word_writer
// Description : Buffers 32-bit word write requests and writes each one to a
//               16-bit asynchronous SRAM as two half-word cycles, low half
//               first. Byte address B maps to half-addresses 2*(B>>2) (low)
//               and 2*(B>>2)+1 (high), wrapping modulo 2^ADDR_W.
//   clock       in   single clock, rising edge
//   reset       in   asynchronous reset, active LOW
//   req_valid   in   write request present
//   req_ready   out  request FIFO not full
//   req_addr    in   byte address of word (bits [1:0] ignored)
//   req_data    in   word to write
//   busy        out  FIFO non-empty or write sequence in progress
//   wr_done     out  one-cycle pulse in the high half's HOLD cycle
//   sram_addr   out  SRAM half-word address
//   sram_dq_o   out  SRAM write data
//   sram_dq_oe  out  SRAM data bus drive enable
//   sram_we_n   out  SRAM write enable, active low
// Revision    : 1.0 - initial release
// ============================================================================
module sram_word_writer
    import sram_word_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 1,
    parameter int ADDR_W     = 18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_data,
    output logic                busy,
    output logic                wr_done,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    output logic                sram_dq_oe,
    output logic                sram_we_n
);

    localparam int ENTRY_W = ADDR_W + 32;
    localparam int WCNT_W  = $clog2(WE_CYCLES + 1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [ENTRY_W-1:0]         w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic [ADDR_W-1:0]          w_head_addr;
    logic [ADDR_W-1:0]          w_head_base;
    logic [31:0]                w_head_data;
    logic                       w_pulse_last;
    logic [ADDR_W-1:0]          r_sram_addr;
    logic [SRAM_DW-1:0]         r_sram_dq;
    logic [SRAM_DW-1:0]         r_hi_data;
    logic [WCNT_W-1:0]          r_we_cnt;

    assign w_push = req_valid && req_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst_n       (reset),
        .i_push      (w_push),
        .i_push_data ({req_addr, req_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign w_head_addr = w_head[ENTRY_W-1 -: ADDR_W];
    assign w_head_data = w_head[31:0];
    // Drop the byte offset, then scale the word index to half-words
    assign w_head_base = (w_head_addr >> 2) << 1;

    // A new word is taken from the FIFO only where the sequencer may start one
    assign w_pop = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_HOLD_H));

    assign w_pulse_last = (r_we_cnt == WCNT_W'(1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (!w_empty) w_next_state = ST_SETUP_L;
            ST_SETUP_L: w_next_state = ST_PULSE_L;
            ST_PULSE_L: if (w_pulse_last) w_next_state = ST_HOLD_L;
            ST_HOLD_L:  w_next_state = ST_SETUP_H;
            ST_SETUP_H: w_next_state = ST_PULSE_H;
            ST_PULSE_H: if (w_pulse_last) w_next_state = ST_HOLD_H;
            // Chain straight into the next word when one is waiting
            ST_HOLD_H:  w_next_state = w_empty ? ST_IDLE : ST_SETUP_L;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address/data only move on SETUP entry so they are stable while WE is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sram_addr <= '0;
            r_sram_dq   <= '0;
            r_hi_data   <= '0;
            r_we_cnt    <= '0;
        end else begin
            if (w_pop) begin
                r_sram_addr <= w_head_base + ADDR_W'(HALF_LO);
                r_sram_dq   <= w_head_data[SRAM_DW-1:0];
                r_hi_data   <= w_head_data[31:SRAM_DW];
            end else if ((r_state == ST_HOLD_L) && (w_next_state == ST_SETUP_H)) begin
                r_sram_addr <= r_sram_addr + ADDR_W'(HALF_HI);
                r_sram_dq   <= r_hi_data;
            end

            if ((r_state == ST_SETUP_L) || (r_state == ST_SETUP_H)) begin
                r_we_cnt <= WCNT_W'(WE_CYCLES);
            end else if ((r_state == ST_PULSE_L) || (r_state == ST_PULSE_H)) begin
                r_we_cnt <= r_we_cnt - 1'b1;
            end
        end
    end

    // Strobes decode directly from the state register so an async reset
    // releases the bus and raises WE in the same instant
    assign sram_we_n  = !((r_state == ST_PULSE_L) || (r_state == ST_PULSE_H));
    assign sram_dq_oe = (r_state != ST_IDLE);
    assign wr_done    = (r_state == ST_HOLD_H);
    assign sram_addr  = r_sram_addr;
    assign sram_dq_o  = r_sram_dq;
    assign req_ready  = !w_full;
    assign busy       = (r_state != ST_IDLE) || (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_sram_word_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_word_writer
// Description : Self-checking bench for sram_word_writer. Two instances run
//               side by side: A with default parameters, B with WE_CYCLES=3.
//               A reference model derives the expected SRAM half-word writes
//               from each accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_word_writer;

    localparam int AW = 18;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } req_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        int            len;
        bit            stable;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;

    logic          valid_a, ready_a, busy_a, done_a, oe_a, we_a;
    logic [AW-1:0] addr_a;
    logic [15:0]   dq_a;
    logic          valid_b, ready_b, busy_b, done_b, oe_b, we_b;
    logic [AW-1:0] addr_b;
    logic [15:0]   dq_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sram_word_writer #(.FIFO_DEPTH(4), .WE_CYCLES(1), .ADDR_W(AW)) dut_a (
        .clock(clock), .reset(reset), .req_valid(valid_a), .req_ready(ready_a),
        .req_addr(req_addr), .req_data(req_data), .busy(busy_a), .wr_done(done_a),
        .sram_addr(addr_a), .sram_dq_o(dq_a), .sram_dq_oe(oe_a), .sram_we_n(we_a)
    );

    sram_word_writer #(.FIFO_DEPTH(4), .WE_CYCLES(3), .ADDR_W(AW)) dut_b (
        .clock(clock), .reset(reset), .req_valid(valid_b), .req_ready(ready_b),
        .req_addr(req_addr), .req_data(req_data), .busy(busy_b), .wr_done(done_b),
        .sram_addr(addr_b), .sram_dq_o(dq_b), .sram_dq_oe(oe_b), .sram_we_n(we_b)
    );

    // ------------------------------------------------------------------
    // Bus monitors: one record per WE pulse, taken at the first cycle WE
    // is high again (the HOLD cycle); also a behavioural SRAM image for A.
    // ------------------------------------------------------------------
    wr_t           wq_a[$], wq_b[$];
    int            done_a_q[$], done_b_q[$];
    logic [15:0]   mem_a [int];
    logic          pw_a = 1'b1, pw_b = 1'b1;
    int            len_a, len_b;
    logic [AW-1:0] pa_a, pa_b;
    logic [15:0]   pd_a, pd_b;
    bit            st_a, st_b;

    always @(negedge clock) begin
        wr_t w;
        if (done_a) done_a_q.push_back(cyc);
        if (!we_a) begin
            if (pw_a) begin len_a = 1; pa_a = addr_a; pd_a = dq_a; st_a = oe_a; end
            else begin
                len_a++;
                if (addr_a !== pa_a || dq_a !== pd_a || !oe_a) st_a = 1'b0;
            end
        end else if (!pw_a) begin
            w.a = pa_a; w.d = pd_a; w.len = len_a;
            w.stable = st_a && oe_a && (addr_a === pa_a) && (dq_a === pd_a);
            wq_a.push_back(w);
            mem_a[int'(pa_a)] = pd_a;
        end
        pw_a = we_a;
    end

    always @(negedge clock) begin
        wr_t w;
        if (done_b) done_b_q.push_back(cyc);
        if (!we_b) begin
            if (pw_b) begin len_b = 1; pa_b = addr_b; pd_b = dq_b; st_b = oe_b; end
            else begin
                len_b++;
                if (addr_b !== pa_b || dq_b !== pd_b || !oe_b) st_b = 1'b0;
            end
        end else if (!pw_b) begin
            w.a = pa_b; w.d = pd_b; w.len = len_b;
            w.stable = st_b && oe_b && (addr_b === pa_b) && (dq_b === pd_b);
            wq_b.push_back(w);
        end
        pw_b = we_b;
    end

    // ------------------------------------------------------------------
    // Reference address mapping, plain arithmetic on the byte address
    // ------------------------------------------------------------------
    function automatic logic [AW-1:0] lo_of(input logic [AW-1:0] b);
        int unsigned x;
        x = b;
        return AW'(((x / 4) * 2) % (1 << AW));
    endfunction

    function automatic logic [AW-1:0] hi_of(input logic [AW-1:0] b);
        int unsigned x;
        x = b;
        return AW'(((x / 4) * 2 + 1) % (1 << AW));
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic send(input bit on_b, input logic [AW-1:0] a, input logic [31:0] d,
                        output int edge_no);
        req_addr = a;
        req_data = d;
        if (on_b) valid_b = 1'b1; else valid_a = 1'b1;
        edge_no = -1;
        for (int i = 0; i < 300; i++) begin
            if (on_b ? ready_b : ready_a) begin
                edge_no = cyc + 1;
                @(negedge clock);
                break;
            end
            @(negedge clock);
        end
        if (edge_no < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: req_ready stayed %b, required 1", on_b ? ready_b : ready_a);
        end
    endtask

    task automatic wait_idle(input bit on_b);
        int n;
        n = 0;
        while ((on_b ? busy_b : busy_a) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
        end
        @(negedge clock);
    endtask

    // Sends a list of words and compares every resulting SRAM write with the model
    task automatic run_words(input bit on_b, input req_t reqs[$], input int gap_max,
                             input string name, output int acc[$]);
        int   s, w, e, idx;
        wr_t  got;
        logic [AW-1:0] ea;
        logic [15:0]   ed;
        s = on_b ? wq_b.size() : wq_a.size();
        w = on_b ? 3 : 1;
        acc = {};
        foreach (reqs[i]) begin
            send(on_b, reqs[i].a, reqs[i].d, e);
            acc.push_back(e);
            if (gap_max > 0) begin
                valid_a = 1'b0; valid_b = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(negedge clock);
            end
        end
        valid_a = 1'b0; valid_b = 1'b0;
        wait_idle(on_b);
        foreach (reqs[i]) begin
            for (int h = 0; h < 2; h++) begin
                ea  = h ? hi_of(reqs[i].a) : lo_of(reqs[i].a);
                ed  = h ? reqs[i].d[31:16] : reqs[i].d[15:0];
                idx = s + 2 * i + h;
                n_cmp++;
                if (idx >= (on_b ? wq_b.size() : wq_a.size())) begin
                    n_bad++;
                    $display("FAIL %s write[%0d]: got none, want addr=%h data=%h", name, idx - s, ea, ed);
                end else begin
                    got = on_b ? wq_b[idx] : wq_a[idx];
                    if (got.a !== ea || got.d !== ed || got.len != w || !got.stable) begin
                        n_bad++;
                        $display("FAIL %s write[%0d]: got addr=%h data=%h we_len=%0d stable=%0d, want addr=%h data=%h we_len=%0d stable=1",
                                 name, idx - s, got.a, got.d, got.len, got.stable, ea, ed, w);
                    end
                end
            end
        end
        n_cmp++;
        if ((on_b ? wq_b.size() : wq_a.size()) != s + 2 * reqs.size()) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d, want %0d", name,
                     (on_b ? wq_b.size() : wq_a.size()) - s, 2 * reqs.size());
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        req_addr = '0; req_data = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({we_a, oe_a, done_a, busy_a} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_strobes: got we_n,oe,done,busy=%b%b%b%b, want 1000", we_a, oe_a, done_a, busy_a);
        end
        n_cmp++;
        if (addr_a !== '0 || dq_a !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got addr=%h dq=%h, want 0/0", addr_a, dq_a);
        end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got ready_a=%b ready_b=%b busy_b=%b, want 1 1 0", ready_a, ready_b, busy_b);
        end
    endtask

    task automatic test_single();
        req_t q[$];
        int   acc[$];
        int   ds;
        ds = done_a_q.size();
        q = '{'{a: 18'h00010, d: 32'hDEADBEEF}};
        run_words(1'b0, q, 0, "single", acc);
        n_cmp++;
        if (done_a_q.size() != ds + 1) begin
            n_bad++;
            $display("FAIL single_done_count: got %0d pulses, want 1", done_a_q.size() - ds);
        end else if (done_a_q[ds] - (acc[0] - 1) != 2 * (2 + 1) + 1) begin
            n_bad++;
            $display("FAIL single_latency: got %0d cycles, want 7", done_a_q[ds] - (acc[0] - 1));
        end
    endtask

    task automatic test_unaligned();
        req_t q[$];
        int   acc[$];
        q = '{'{a: 18'h00013, d: 32'h12345678}};
        run_words(1'b0, q, 0, "unaligned", acc);
    endtask

    task automatic test_back_to_back();
        req_t q[$];
        req_t r;
        int   acc[$];
        int   ds;
        ds = done_a_q.size();
        for (int i = 0; i < 6; i++) begin
            r.a = AW'($urandom); r.d = $urandom;
            q.push_back(r);
        end
        run_words(1'b0, q, 0, "b2b", acc);
        for (int i = 1; i < 5; i++) begin
            n_cmp++;
            if (acc[i] != acc[0] + i) begin
                n_bad++;
                $display("FAIL b2b_accept[%0d]: got edge %0d, want %0d", i, acc[i], acc[0] + i);
            end
        end
        n_cmp++;
        if (acc[5] <= acc[4] + 1) begin
            n_bad++;
            $display("FAIL b2b_ready_drop: 6th accepted at edge %0d, want later than %0d", acc[5], acc[4] + 1);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (done_a_q.size() < ds + 6) begin
                n_bad++;
                $display("FAIL b2b_done_count: got %0d pulses, want 6", done_a_q.size() - ds);
                break;
            end else if (done_a_q[ds + i + 1] - done_a_q[ds + i] != 6) begin
                n_bad++;
                $display("FAIL b2b_gap[%0d]: got %0d cycles between wr_done, want 6", i,
                         done_a_q[ds + i + 1] - done_a_q[ds + i]);
            end
        end
    endtask

    task automatic test_we_cycles3();
        req_t q[$];
        req_t r;
        int   acc[$];
        int   ds;
        ds = done_b_q.size();
        for (int i = 0; i < 2; i++) begin
            r.a = AW'($urandom); r.d = $urandom;
            q.push_back(r);
        end
        run_words(1'b1, q, 0, "we3", acc);
        n_cmp++;
        if (done_b_q.size() < ds + 1) begin
            n_bad++;
            $display("FAIL we3_done: got no wr_done, want one");
        end else if (done_b_q[ds] - (acc[0] - 1) != 2 * (2 + 3) + 1) begin
            n_bad++;
            $display("FAIL we3_latency: got %0d cycles, want 11", done_b_q[ds] - (acc[0] - 1));
        end
    endtask

    task automatic test_random();
        req_t q[$];
        req_t r;
        int   acc[$];
        for (int i = 0; i < 16; i++) begin
            r.a = AW'($urandom); r.d = $urandom;
            q.push_back(r);
        end
        run_words(1'b0, q, 3, "random", acc);
    endtask

    task automatic test_top_addr();
        req_t          q[$];
        int            acc[$];
        int            lo;
        logic [31:0]   rd;
        q = '{'{a: 18'h3FFFC, d: 32'hA5A55A5A}};
        run_words(1'b0, q, 0, "top_addr", acc);
        // Read back with the fetch-path mapping: (B>>1) low, (B>>1)+1 high
        lo = 32'h3FFFC >> 1;
        n_cmp++;
        if (!mem_a.exists(lo) || !mem_a.exists(lo + 1)) begin
            n_bad++;
            $display("FAIL top_addr_readback: got no data at %h/%h, want a5a55a5a", lo, lo + 1);
        end else begin
            rd = {mem_a[lo + 1], mem_a[lo]};
            if (rd !== 32'hA5A55A5A) begin
                n_bad++;
                $display("FAIL top_addr_readback: got %h, want a5a55a5a", rd);
            end
        end
    endtask

    task automatic test_reset_abort();
        int  e, n, sz;
        bit  hit;
        send(1'b0, AW'($urandom), $urandom, e);
        send(1'b0, AW'($urandom), $urandom, e);
        valid_a = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!we_a && addr_a[0]) begin hit = 1'b1; break; end
            @(negedge clock);
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL abort_find_pulse_h: got no high-half pulse, want one");
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (we_a !== 1'b1 || oe_a !== 1'b0 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_async: got we_n=%b oe=%b busy=%b, want 1 0 0", we_a, oe_a, busy_a);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sz = wq_a.size();
        n_cmp++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_release: got ready=%b busy=%b, want 1 0", ready_a, busy_a);
        end
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy_a || !we_a) n++;
        end
        n_cmp++;
        if (n != 0 || wq_a.size() != sz) begin
            n_bad++;
            $display("FAIL abort_fifo_empty: got %0d active cycles and %0d writes, want 0 and 0", n, wq_a.size() - sz);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_unaligned();
        test_back_to_back();
        test_we_cycles3();
        test_random();
        test_top_addr();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
